// File: rtl/parity_pkg.sv
// parity_pkg: shared mode encodings, frame FSM states and counter sizing for parity link blocks
package parity_pkg;
  localparam logic MODE_GEN = 1'b0;
  localparam logic MODE_CHK = 1'b1;
  typedef enum logic [1:0] {DATA, GEN, CHK} state_t;
  function automatic int cnt_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/parity_word_xor.sv
// parity_word_xor: combinational XOR-reduction of a DATA_W word (data in, par out)
module parity_word_xor #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] data,
  output logic              par
);
  assign par = ^data;
endmodule

// File: rtl/parity_frame_codec.sv
// parity_frame_codec: framed parity generator/checker on valid/ready streams (s_* in, m_* out, err/err_cnt status)
module parity_frame_codec
  import parity_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FRAME_LEN  = 4,
  parameter int ODD_PARITY = 0,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_par,
  output logic              m_last,
  output logic              err,
  output logic [CNT_W-1:0]  err_cnt
);
  localparam int CW = cnt_width(FRAME_LEN);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic acc, mode_q, wpar, take, load_ok, last, cur_mode, exp_par;
  parity_word_xor #(.DATA_W(DATA_W)) u_xor (.data(s_data), .par(wpar));
  assign load_ok  = !m_valid || m_ready;
  assign s_ready  = state != GEN && load_ok;
  assign take     = s_valid && s_ready;
  assign last     = cnt == CW'(FRAME_LEN - 1);
  assign cur_mode = cnt == '0 ? mode : mode_q;
  assign exp_par  = acc ^ (ODD_PARITY != 0);
  always_comb begin
    state_n = state == DATA ? (take && last ? (cur_mode == MODE_CHK ? CHK : GEN) : DATA) :
              state == GEN  ? (load_ok ? DATA : GEN) :
                              (take ? DATA : CHK);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= DATA;
      cnt     <= '0;
      acc     <= 1'b0;
      mode_q  <= MODE_GEN;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_par   <= 1'b0;
      m_last  <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      state <= state_n;
      err   <= 1'b0;
      if (m_valid && m_ready) m_valid <= 1'b0;
      if (state == DATA && take) begin
        cnt     <= last ? '0 : cnt + 1'b1;
        acc     <= acc ^ wpar;
        mode_q  <= cur_mode;
        m_valid <= 1'b1;
        m_data  <= s_data;
        m_par   <= 1'b0;
        m_last  <= 1'b0;
      end
      if (state == GEN && load_ok) begin
        acc     <= 1'b0;
        m_valid <= 1'b1;
        m_data  <= DATA_W'(exp_par);
        m_par   <= 1'b1;
        m_last  <= 1'b1;
      end
      if (state == CHK && take) begin
        acc     <= 1'b0;
        m_valid <= 1'b1;
        m_data  <= s_data;
        m_par   <= 1'b1;
        m_last  <= 1'b1;
        if (s_data[0] != exp_par) begin
          err <= 1'b1;
          if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_parity_frame_codec.sv
// tb_parity_frame_codec: scoreboard bench driving an even and an odd parity codec with shared stimulus
module tb_parity_frame_codec;
  logic clk = 0, rst = 1, mode = 0, s_valid = 0, m_ready = 1;
  logic [7:0] s_data = 0;
  logic s_ready0, s_ready1, m_valid0, m_valid1, m_par0, m_par1, m_last0, m_last1, err0, err1;
  logic [7:0] m_data0, m_data1;
  logic [1:0] err_cnt0, err_cnt1;
  typedef struct {logic [7:0] d0; logic [7:0] d1; logic par;} exp_t;
  typedef struct {string name; logic [31:0] act; logic [31:0] exp;} chk_t;
  exp_t q[$];
  chk_t pend[$];
  int n_cmp = 0, n_bad = 0, errs0 = 0, errs1 = 0;
  logic hold_v = 0;
  logic [7:0] hold_d0 = 0, hold_d1 = 0;
  always #5 clk = ~clk;
  parity_frame_codec #(.DATA_W(8), .FRAME_LEN(4), .ODD_PARITY(0), .CNT_W(2)) dut0 (
    .clk(clk), .rst(rst), .mode(mode), .s_valid(s_valid), .s_ready(s_ready0), .s_data(s_data),
    .m_valid(m_valid0), .m_ready(m_ready), .m_data(m_data0), .m_par(m_par0), .m_last(m_last0),
    .err(err0), .err_cnt(err_cnt0));
  parity_frame_codec #(.DATA_W(8), .FRAME_LEN(4), .ODD_PARITY(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .mode(mode), .s_valid(s_valid), .s_ready(s_ready1), .s_data(s_data),
    .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1), .m_par(m_par1), .m_last(m_last1),
    .err(err1), .err_cnt(err_cnt1));
  task automatic cmp(input string n, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    pend.push_back('{n, a, e});
  endtask
  always @(negedge clk) begin
    exp_t e;
    while (pend.size() > 0) begin
      chk_t c;
      c = pend.pop_front();
      cmp(c.name, c.act, c.exp);
    end
    if (rst) hold_v = 0;
    else begin
      if (err0) errs0++;
      if (err1) errs1++;
      cmp("sready_eq", s_ready1, s_ready0);
      cmp("mvalid_eq", m_valid1, m_valid0);
      if (hold_v && m_valid0) begin
        cmp("hold_d0", m_data0, hold_d0);
        cmp("hold_d1", m_data1, hold_d1);
      end
      if (m_valid0 && m_ready) begin
        if (q.size() == 0) cmp("q_size", q.size(), 1);
        else begin
          e = q.pop_front();
          cmp("m_data0", m_data0, e.d0);
          cmp("m_data1", m_data1, e.d1);
          cmp("m_par", m_par0, e.par);
          cmp("m_last", m_last0, e.par);
          cmp("m_par1", m_par1, e.par);
        end
      end
      hold_v  = m_valid0 && !m_ready;
      hold_d0 = m_data0;
      hold_d1 = m_data1;
    end
  end
  task automatic send(input logic [7:0] d, input logic par);
    bit ok = 0;
    q.push_back('{d, d, par});
    s_data = d;
    s_valid = 1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = s_ready0;
      @(posedge clk);
    end
    #1 s_valid = 0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask
  task automatic push_par(input logic [7:0] p0, input logic [7:0] p1);
    q.push_back('{p0, p1, 1'b1});
  endtask
  task automatic frame(input logic [7:0] a, b, c, d);
    send(a, 0);
    send(b, 0);
    send(c, 0);
    send(d, 0);
  endtask
  task automatic drain();
    for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) chk("drain_timeout", q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid", m_valid0, 0);
    chk("rst_m_data", m_data0, 0);
    chk("rst_m_par", m_par0, 0);
    chk("rst_m_last", m_last0, 0);
    chk("rst_err", err0, 0);
    chk("rst_err_cnt", err_cnt0, 0);
    rst = 0;
    #1 chk("rst_s_ready", s_ready0, 1);
    @(posedge clk);
    #1;
    frame(8'h01, 8'h03, 8'h00, 8'hFF);
    push_par(8'h01, 8'h00);
    @(negedge clk) chk("gen_stall", s_ready0, 0);
    @(negedge clk) chk("gen_resume", s_ready0, 1);
    @(posedge clk);
    #1;
    mode = 1;
    frame(8'h0F, 8'h10, 8'h00, 8'h00);
    send(8'h01, 1);
    drain();
    chk("chk1_errs0", errs0, 0);
    chk("chk1_errs1", errs1, 1);
    frame(8'h0F, 8'h10, 8'h00, 8'h00);
    send(8'h00, 1);
    drain();
    chk("chk2_errs0", errs0, 1);
    chk("chk2_errs1", errs1, 1);
    chk("chk2_cnt0", err_cnt0, 1);
    chk("chk2_cnt1", err_cnt1, 1);
    mode = 0;
    send(8'h12, 0);
    send(8'h34, 0);
    m_ready = 0;
    repeat (3) @(negedge clk) chk("bp_s_ready", s_ready0, 0);
    @(posedge clk);
    #1 m_ready = 1;
    send(8'h56, 0);
    send(8'h78, 0);
    push_par(8'h01, 8'h00);
    drain();
    send(8'h80, 0);
    mode = 1;
    send(8'h01, 0);
    send(8'h02, 0);
    send(8'h04, 0);
    push_par(8'h00, 8'h01);
    frame(8'h03, 8'h03, 8'h03, 8'h03);
    send(8'h00, 1);
    drain();
    chk("toggle_errs0", errs0, 1);
    chk("toggle_errs1", errs1, 2);
    mode = 0;
    send(8'h01, 0);
    send(8'h01, 0);
    rst = 1;
    #1;
    chk("mid_rst_m_valid", m_valid0, 0);
    chk("mid_rst_m_data", m_data0, 0);
    chk("mid_rst_err_cnt", err_cnt0, 0);
    q.delete();
    @(posedge clk);
    #1 rst = 0;
    @(posedge clk);
    #1;
    frame(8'h07, 8'h00, 8'h00, 8'h00);
    push_par(8'h01, 8'h00);
    drain();
    mode = 1;
    for (int i = 0; i < 5; i++) begin
      frame(8'h01, 8'h00, 8'h00, 8'h00);
      send(8'h00, 1);
      if (i == 2) begin
        drain();
        chk("sat3_cnt0", err_cnt0, 3);
      end
    end
    drain();
    chk("sat5_cnt0", err_cnt0, 3);
    chk("sat5_cnt1", err_cnt1, 0);
    chk("sat5_errs0", errs0, 6);
    chk("sat5_errs1", errs1, 2);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
